// File: rtl/vesa_timing_gen_cfg.sv
// Runtime-configurable VESA timing generator with shadowed geometry/polarity.
// Config is staged in a pending register and copied to the shadow at frame wrap (or at once in IDLE).
module vesa_timing_gen_cfg #(
  parameter int CNT_W    = 16,
  parameter int FCNT_W   = 16,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 31,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_h_active,
  input  logic [CNT_W-1:0]  cfg_h_fp,
  input  logic [CNT_W-1:0]  cfg_h_sync,
  input  logic [CNT_W-1:0]  cfg_h_bp,
  input  logic [CNT_W-1:0]  cfg_v_active,
  input  logic [CNT_W-1:0]  cfg_v_fp,
  input  logic [CNT_W-1:0]  cfg_v_sync,
  input  logic [CNT_W-1:0]  cfg_v_bp,
  input  logic              cfg_hs_pol,
  input  logic              cfg_vs_pol,
  input  logic              cfg_update,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_valid,
  output logic [CNT_W-1:0]  h_count,
  output logic [CNT_W-1:0]  v_count,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int TW = CNT_W + 2;
  localparam logic [TW-1:0] TOT_MAX = (TW'(1) << CNT_W) - TW'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] ha;
    logic [CNT_W-1:0] hfp;
    logic [CNT_W-1:0] hsy;
    logic [CNT_W-1:0] hbp;
    logic [CNT_W-1:0] va;
    logic [CNT_W-1:0] vfp;
    logic [CNT_W-1:0] vsy;
    logic [CNT_W-1:0] vbp;
    logic             hpol;
    logic             vpol;
  } geom_t;

  localparam geom_t GEOM_RST = '{
    ha: CNT_W'(H_ACTIVE), hfp: CNT_W'(H_FP), hsy: CNT_W'(H_SYNC), hbp: CNT_W'(H_BP),
    va: CNT_W'(V_ACTIVE), vfp: CNT_W'(V_FP), vsy: CNT_W'(V_SYNC), vbp: CNT_W'(V_BP),
    hpol: 1'(HS_POL), vpol: 1'(VS_POL)
  };

  function automatic logic [TW-1:0] sum4(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b,
                                         input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
    return TW'(a) + TW'(b) + TW'(c) + TW'(d);
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    h_q, h_d, v_q, v_d;
  geom_t               shadow_q, shadow_d, pend_q, pend_d, cfg_geom;
  logic                pend_valid_q, pend_valid_d;
  logic                cfg_ack_q, cfg_ack_d, cfg_err_q, cfg_err_d;
  logic                hsync_q, hsync_d, vsync_q, vsync_d;
  logic                de_q, de_d, frame_valid_q, frame_valid_d;
  logic                line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]       ht, vt, h_tot_cfg, v_tot_cfg;
  logic [TW-1:0]       h_ext, v_ext, hs_lo, hs_hi, vs_lo, vs_hi;
  logic                h_last, v_last, apply, cfg_ok;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cfg_ack_d    = 1'b0;
    cfg_err_d    = cfg_err_q;
    frame_cnt_d  = frame_cnt_q + FCNT_W'(frame_start_q);
    apply        = 1'b0;

    ht     = sum4(shadow_q.ha, shadow_q.hfp, shadow_q.hsy, shadow_q.hbp);
    vt     = sum4(shadow_q.va, shadow_q.vfp, shadow_q.vsy, shadow_q.vbp);
    h_last = (TW'(h_q) == ht - TW'(1));
    v_last = (TW'(v_q) == vt - TW'(1));

    case (state_q)
      IDLE: begin
        h_d   = '0;
        v_d   = '0;
        apply = pend_valid_q;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_last) begin
          h_d = '0;
          if (v_last) begin
            v_d   = '0;
            apply = pend_valid_q;
            if (!en) state_d = IDLE;
          end else begin
            v_d = v_q + CNT_W'(1);
          end
        end else begin
          h_d = h_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Apply uses the old pending value so a same-cycle capture stays pending.
    if (apply) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
      cfg_ack_d    = 1'b1;
    end

    cfg_geom = '{
      ha: cfg_h_active, hfp: cfg_h_fp, hsy: cfg_h_sync, hbp: cfg_h_bp,
      va: cfg_v_active, vfp: cfg_v_fp, vsy: cfg_v_sync, vbp: cfg_v_bp,
      hpol: cfg_hs_pol, vpol: cfg_vs_pol
    };
    h_tot_cfg = sum4(cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp);
    v_tot_cfg = sum4(cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp);
    cfg_ok    = (cfg_h_active != '0) && (cfg_h_sync != '0) &&
                (cfg_v_active != '0) && (cfg_v_sync != '0) &&
                (h_tot_cfg <= TOT_MAX) && (v_tot_cfg <= TOT_MAX);

    if (cfg_update) begin
      if (cfg_ok) begin
        pend_d       = cfg_geom;
        pend_valid_d = 1'b1;
        cfg_err_d    = 1'b0;
      end else begin
        cfg_err_d    = 1'b1;
      end
    end

    // Outputs are decoded from the next position and geometry so they register alongside the counts.
    h_ext = TW'(h_d);
    v_ext = TW'(v_d);
    hs_lo = TW'(shadow_d.ha) + TW'(shadow_d.hfp);
    hs_hi = hs_lo + TW'(shadow_d.hsy);
    vs_lo = TW'(shadow_d.va) + TW'(shadow_d.vfp);
    vs_hi = vs_lo + TW'(shadow_d.vsy);

    de_d          = 1'b0;
    frame_valid_d = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    hsync_d       = ~shadow_d.hpol;
    vsync_d       = ~shadow_d.vpol;
    if (state_d == RUN) begin
      frame_valid_d = (v_ext < TW'(shadow_d.va));
      de_d          = frame_valid_d && (h_ext < TW'(shadow_d.ha));
      hsync_d       = ((h_ext >= hs_lo) && (h_ext < hs_hi)) ? shadow_d.hpol : ~shadow_d.hpol;
      vsync_d       = ((v_ext >= vs_lo) && (v_ext < vs_hi)) ? shadow_d.vpol : ~shadow_d.vpol;
      line_start_d  = (h_d == '0);
      frame_start_d = line_start_d && (v_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      shadow_q      <= GEOM_RST;
      pend_q        <= GEOM_RST;
      pend_valid_q  <= 1'b0;
      cfg_ack_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      hsync_q       <= ~1'(HS_POL);
      vsync_q       <= ~1'(VS_POL);
      de_q          <= 1'b0;
      frame_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      cfg_ack_q     <= cfg_ack_d;
      cfg_err_q     <= cfg_err_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_valid_q <= frame_valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign cfg_ack     = cfg_ack_q;
  assign cfg_err     = cfg_err_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_valid = frame_valid_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vesa_timing_gen_cfg.sv
// Bench for vesa_timing_gen_cfg: position/geometry reference model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized en/config traffic.
module tb_vesa_timing_gen_cfg;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_update, cfg_hs_pol, cfg_vs_pol;
  logic [15:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [15:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic        cfg_ack, cfg_err, hsync, vsync, de, frame_valid, line_start, frame_start;
  logic [15:0] h_count, v_count, frame_cnt;

  always #5 clk = ~clk;

  vesa_timing_gen_cfg dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_update(cfg_update),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_valid(frame_valid), .h_count(h_count), .v_count(v_count),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hp, vp;
  } geo_t;

  geo_t def_geo = '{1920, 88, 44, 148, 1080, 4, 5, 31, 1'b1, 1'b1};
  geo_t act_geo, pend_geo;

  int checks = 0;
  int failures = 0;
  bit m_known = 1'b0;
  bit m_run, m_ack, m_err, m_pend;
  int m_h, m_v, m_fcnt;
  int cyc_since_fs = 0, de_since_fs = 0, last_len = 0, last_de = 0, ack_seen = 0;

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      if (failures >= 50) finish_run();
    end
  endtask

  function automatic bit geo_ok(input geo_t g);
    int ht, vt;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    return (g.ha >= 1) && (g.hs >= 1) && (g.va >= 1) && (g.vs >= 1) && (ht <= 65535) && (vt <= 65535);
  endfunction

  function automatic geo_t cfg_now();
    geo_t g;
    g = '{int'(cfg_h_active), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
          int'(cfg_v_active), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp),
          cfg_hs_pol, cfg_vs_pol};
    return g;
  endfunction

  // Advances the reference by one clock using the inputs sampled at that edge.
  task automatic model_update();
    bit prev_fs, at_wrap, do_apply;
    int ht, vt;
    geo_t cap;
    if (!rst_n) begin
      m_known = 1'b1; m_run = 1'b0; m_h = 0; m_v = 0; m_fcnt = 0;
      m_ack = 1'b0; m_err = 1'b0; m_pend = 1'b0; act_geo = def_geo;
      return;
    end
    if (!m_known) return;
    ht = act_geo.ha + act_geo.hfp + act_geo.hs + act_geo.hbp;
    vt = act_geo.va + act_geo.vfp + act_geo.vs + act_geo.vbp;
    prev_fs  = m_run && (m_h == 0) && (m_v == 0);
    at_wrap  = m_run && (m_h == ht - 1) && (m_v == vt - 1);
    do_apply = m_pend && (!m_run || at_wrap);
    if (!m_run) begin
      m_h = 0; m_v = 0;
      if (en) m_run = 1'b1;
    end else if (m_h == ht - 1) begin
      m_h = 0;
      if (m_v == vt - 1) begin
        m_v = 0;
        if (!en) m_run = 1'b0;
      end else m_v++;
    end else m_h++;
    m_ack = do_apply;
    if (do_apply) begin act_geo = pend_geo; m_pend = 1'b0; end
    if (cfg_update) begin
      cap = cfg_now();
      if (geo_ok(cap)) begin pend_geo = cap; m_pend = 1'b1; m_err = 1'b0; end
      else m_err = 1'b1;
    end
    if (prev_fs) m_fcnt = (m_fcnt + 1) % 65536;
  endtask

  task automatic compare_all();
    logic [63:0] exp_v, act_v;
    bit e_hs, e_vs, e_de, e_fv, e_ls, e_fs;
    int hs_lo, vs_lo;
    if (!m_known) return;
    hs_lo = act_geo.ha + act_geo.hfp;
    vs_lo = act_geo.va + act_geo.vfp;
    e_hs = ~act_geo.hp; e_vs = ~act_geo.vp;
    e_de = 0; e_fv = 0; e_ls = 0; e_fs = 0;
    if (m_run) begin
      e_fv = (m_v < act_geo.va);
      e_de = e_fv && (m_h < act_geo.ha);
      e_hs = (m_h >= hs_lo && m_h < hs_lo + act_geo.hs) ? act_geo.hp : ~act_geo.hp;
      e_vs = (m_v >= vs_lo && m_v < vs_lo + act_geo.vs) ? act_geo.vp : ~act_geo.vp;
      e_ls = (m_h == 0);
      e_fs = e_ls && (m_v == 0);
    end
    exp_v = {8'h0, e_hs, e_vs, e_de, e_fv, e_ls, e_fs, m_ack, m_err, 16'(m_h), 16'(m_v), 16'(m_fcnt)};
    act_v = {8'h0, hsync, vsync, de, frame_valid, line_start, frame_start, cfg_ack, cfg_err,
             h_count, v_count, frame_cnt};
    check_output($sformatf("cycle_h%0d_v%0d", m_h, m_v), act_v, exp_v);
    if (frame_start === 1'b1) begin
      last_len = cyc_since_fs; last_de = de_since_fs;
      cyc_since_fs = 0; de_since_fs = 0;
    end
    cyc_since_fs++;
    if (de === 1'b1) de_since_fs++;
    if (cfg_ack === 1'b1) ack_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_cfg(input geo_t g);
    cfg_h_active = 16'(g.ha); cfg_h_fp = 16'(g.hfp); cfg_h_sync = 16'(g.hs); cfg_h_bp = 16'(g.hbp);
    cfg_v_active = 16'(g.va); cfg_v_fp = 16'(g.vfp); cfg_v_sync = 16'(g.vs); cfg_v_bp = 16'(g.vbp);
    cfg_hs_pol = g.hp; cfg_vs_pol = g.vp;
  endtask

  task automatic apply_stimulus(input geo_t g);
    drive_cfg(g);
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
  endtask

  task automatic wait_pos(input string name, input int h, input int v, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (h_count == 16'(h) && v_count == 16'(v)) begin hit = 1'b1; break; end
      step();
    end
    check_output(name, 64'(hit), 64'd1);
  endtask

  task automatic wait_ack(input string name, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (cfg_ack === 1'b1) begin hit = 1'b1; break; end
    end
    check_output(name, 64'(hit), 64'd1);
  endtask

  task automatic wait_fs(input string name, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (frame_start === 1'b1) begin hit = 1'b1; break; end
    end
    check_output(name, 64'(hit), 64'd1);
  endtask

  function automatic geo_t rand_geo();
    geo_t g;
    g.ha = $urandom_range(1, 6); g.hfp = $urandom_range(0, 3); g.hs = $urandom_range(1, 3); g.hbp = $urandom_range(0, 3);
    g.va = $urandom_range(1, 5); g.vfp = $urandom_range(0, 2); g.vs = $urandom_range(1, 2); g.vbp = $urandom_range(0, 2);
    g.hp = 1'($urandom_range(0, 1)); g.vp = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 3))
        0: g.hs = 0;
        1: g.va = 0;
        2: g.hfp = 65530;
        default: g.vs = 0;
      endcase
    end
    return g;
  endfunction

  geo_t mode_a = '{6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
  geo_t mode_b = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};

  initial begin
    geo_t g;
    int hs_first, hs_last, hs_cnt, de_line, ls_cnt, vs_first, vs_last;
    int prev_h, prev_v;
    bit idle_hit;

    rst_n = 1'b0; en = 1'b0; cfg_update = 1'b0;
    drive_cfg('{0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0});
    step_n(2);
    check_output("rst_hsync", 64'(hsync), 64'd0);
    check_output("rst_vsync", 64'(vsync), 64'd0);
    check_output("rst_h", 64'(h_count), 64'd0);
    check_output("rst_de", 64'(de), 64'd0);
    check_output("rst_fcnt", 64'(frame_cnt), 64'd0);

    $display("[TB] default geometry run");
    rst_n = 1'b1; en = 1'b1;
    step();
    check_output("first_fs", 64'(frame_start), 64'd1);
    check_output("first_de", 64'(de), 64'd1);
    check_output("first_h", 64'(h_count), 64'd0);
    hs_first = -1; hs_last = -1; hs_cnt = 0; de_line = 0; ls_cnt = 0;
    for (int i = 0; i < 6600; i++) begin
      if (v_count == 16'd0) begin
        if (hsync === 1'b1) begin
          if (hs_first < 0) hs_first = int'(h_count);
          hs_last = int'(h_count);
          hs_cnt++;
        end
        if (de === 1'b1) de_line++;
      end
      if (line_start === 1'b1) ls_cnt++;
      step();
    end
    check_output("def_hs_first", 64'(hs_first), 64'd2008);
    check_output("def_hs_last", 64'(hs_last), 64'd2051);
    check_output("def_hs_cnt", 64'(hs_cnt), 64'd44);
    check_output("def_de_line", 64'(de_line), 64'd1920);
    check_output("def_lines", 64'(ls_cnt), 64'd3);
    check_output("def_fcnt", 64'(frame_cnt), 64'd1);
    check_output("def_pos_v", 64'(v_count), 64'd3);
    check_output("def_de_mid", 64'(de), 64'd1);

    $display("[TB] reset during active video");
    rst_n = 1'b0;
    step();
    check_output("midrst_de", 64'(de), 64'd0);
    check_output("midrst_v", 64'(v_count), 64'd0);
    check_output("midrst_fcnt", 64'(frame_cnt), 64'd0);
    check_output("midrst_ls", 64'(line_start), 64'd0);
    rst_n = 1'b1; en = 1'b0;
    step();

    $display("[TB] idle config load and small-mode apply");
    ack_seen = 0;
    apply_stimulus(mode_a);
    step_n(3);
    check_output("idle_ack_cnt", 64'(ack_seen), 64'd1);
    check_output("idle_h", 64'(h_count), 64'd0);
    en = 1'b1;
    wait_pos("reach_a_v2", 0, 2, 100);
    apply_stimulus(mode_b);
    wait_ack("ack_b", 200);
    check_output("ack_b_fs", 64'(frame_start), 64'd1);
    check_output("old_frame_len", 64'(last_len), 64'd60);
    wait_fs("fs_after_b", 200);
    check_output("b_frame_len", 64'(last_len), 64'd120);
    check_output("b_frame_de", 64'(last_de), 64'd32);

    $display("[TB] polarity change");
    g = mode_b; g.hp = 1'b0; g.vp = 1'b0;
    wait_pos("reach_b_31", 3, 1, 200);
    apply_stimulus(g);
    wait_ack("ack_pol", 200);
    hs_first = -1; hs_last = -1; hs_cnt = 0; vs_first = -1; vs_last = -1;
    for (int i = 0; i < 120; i++) begin
      if (v_count == 16'd0 && hsync === 1'b0) begin
        if (hs_first < 0) hs_first = int'(h_count);
        hs_last = int'(h_count);
        hs_cnt++;
      end
      if (h_count == 16'd0 && vsync === 1'b0) begin
        if (vs_first < 0) vs_first = int'(v_count);
        vs_last = int'(v_count);
      end
      step();
    end
    check_output("pol_hs_first", 64'(hs_first), 64'd10);
    check_output("pol_hs_last", 64'(hs_last), 64'd12);
    check_output("pol_hs_cnt", 64'(hs_cnt), 64'd3);
    check_output("pol_vs_first", 64'(vs_first), 64'd5);
    check_output("pol_vs_last", 64'(vs_last), 64'd6);
    check_output("pol_next_fs", 64'(frame_start), 64'd1);

    $display("[TB] invalid config then valid config");
    g = mode_b; g.hs = 0;
    ack_seen = 0;
    apply_stimulus(g);
    check_output("bad_err", 64'(cfg_err), 64'd1);
    step_n(130);
    check_output("bad_no_ack", 64'(ack_seen), 64'd0);
    check_output("bad_len", 64'(last_len), 64'd120);
    apply_stimulus(mode_b);
    check_output("good_err_clr", 64'(cfg_err), 64'd0);
    wait_ack("ack_good", 200);
    check_output("good_ack_fs", 64'(frame_start), 64'd1);
    wait_pos("reach_h10", 10, 0, 50);
    check_output("good_pol_hs", 64'(hsync), 64'd1);

    $display("[TB] stop and restart");
    wait_pos("reach_stop_v2", 0, 2, 200);
    en = 1'b0;
    idle_hit = 1'b0; prev_h = -1; prev_v = -1;
    for (int i = 0; i < 200; i++) begin
      prev_h = int'(h_count); prev_v = int'(v_count);
      step();
      if (h_count == 16'd0 && line_start === 1'b0) begin idle_hit = 1'b1; break; end
    end
    check_output("stop_idle", 64'(idle_hit), 64'd1);
    check_output("stop_last_h", 64'(prev_h), 64'd14);
    check_output("stop_last_v", 64'(prev_v), 64'd7);
    check_output("stop_de", 64'(de), 64'd0);
    check_output("stop_fv", 64'(frame_valid), 64'd0);
    step_n(3);
    en = 1'b1;
    step();
    check_output("restart_fs", 64'(frame_start), 64'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      drive_cfg(rand_geo());
      cfg_update = ($urandom_range(0, 79) == 0);
      step();
    end
    cfg_update = 1'b0;

    finish_run();
  end

endmodule
